uart_rx_sampler: RTL and testbench
==================================

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, system clock; all logic SHALL be on its rising edge.
REQ-002 The block SHALL have these ports: rst, input, 1, reset; asynchronous, active-low.
REQ-003 The block SHALL have these ports: AcqSig_i, input, 1, one-clk acquisition strobe from the baudrate generator.
REQ-004 The block SHALL have these ports: AcqPerBit_i, input, 5, number of AcqSig_i strobes per bit; legal range 3..16.
REQ-005 The block SHALL have these ports: Rx_i, input, 1, serial line; idle high.
REQ-006 The block SHALL have these ports: ParityOdd_i, input, 1, 1 = odd parity, 0 = even parity; present only with PARITY_CHECK_EN.
REQ-007 The block SHALL have these ports: Data_o, output, 8, last received byte, LSB first on the line.
REQ-008 The block SHALL have these ports: DataValid_o, output, 1, one-clk pulse when the byte is good.
REQ-009 The block SHALL have these ports: FrameErr_o, output, 1, one-clk pulse when the stop bit reads 0.
REQ-010 The block SHALL have these ports: ParityErr_o, output, 1, one-clk pulse on parity mismatch; tied 0 without the macro.
REQ-011 The block SHALL have these ports: Busy_o, output, 1, high in any state other than IDLE.

Function
REQ-012 Rx_i SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value, which resets to 1.
REQ-013 The synchronized line SHALL be sampled only on clk edges where AcqSig_i=1.
REQ-014 The FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 In IDLE, a sample of 0 whose previous AcqSig sample was 1 SHALL move the FSM to START and clear the sample counter.
REQ-016 AcqPerBit_i SHALL be latched at the same time; values below 3 SHALL be latched as 3, and values above 16 as 16.
REQ-017 The sample counter SHALL count AcqSig_i strobes within a bit, from 0 to N-1, where N is the latched AcqPerBit_i.
REQ-018 At N-1 the counter SHALL wrap to 0 and advance to the next bit.
REQ-019 In each bit, samples at indices M-1, M and M+1, with M = N/2 (floor), SHALL feed a 2-of-3 majority vote.
REQ-020 The voted value SHALL be valid on the strobe at index M+1.
REQ-021 In START, a voted 0 SHALL continue the frame; a voted 1 SHALL return the FSM to IDLE with no output pulse (glitch rejection).
REQ-022 In DATA, voted bits SHALL shift into a shift register LSB first; after 8 bits the FSM SHALL go to PARITY (macro) or STOP.
REQ-023 In STOP, the FSM SHALL return to IDLE right after the vote at index M+1 and SHALL NOT wait for the end of the bit.
REQ-024 At the STOP vote, Data_o SHALL take the shift register value.
REQ-025 One clk after the STOP vote, exactly one of these SHALL pulse: DataValid_o, when stop=1 and there is no parity error; or FrameErr_o, when stop=0.
REQ-026 Data_o SHALL hold its value until the next STOP vote.
REQ-027 When the macro is on and the parity is wrong, ParityErr_o SHALL pulse on the same cycle as REQ-025; DataValid_o SHALL stay 0, and FrameErr_o SHALL still report the stop bit on its own.
REQ-028 After a frame error, IDLE SHALL require a sample of 1 before it accepts a new start edge (break handling).
REQ-029 Changes to AcqPerBit_i during a frame SHALL NOT take effect until the next start edge.
REQ-030 If AcqSig_i is held at 0, the FSM and counters SHALL hold their state.

Reset
REQ-031 While rst=0, the FSM SHALL be in IDLE and all counters and the shift register SHALL be 0.
REQ-032 During reset, Data_o SHALL be 8'h00, and DataValid_o, FrameErr_o, ParityErr_o and Busy_o SHALL be 0.
REQ-033 If rst is asserted in the middle of a frame, the frame SHALL be dropped and no pulse SHALL be output after reset is released.

Configuration
REQ-034 When PARITY_CHECK_EN is defined, the PARITY state, the ParityOdd_i port and the parity check SHALL be built in, giving 8-bit + parity + 1 stop framing.
REQ-035 When PARITY_CHECK_EN is not defined, the framing SHALL be 8N1, the ParityOdd_i port SHALL be absent and ParityErr_o SHALL be constant 0.

Verification
REQ-036 N=16, frame 0x55 8N1 -> Data_o=0x55 and one DataValid_o pulse 1 clk after the strobe at index 9 of the stop bit.
REQ-037 N=16, a 0 on the line for only 3 strobes in IDLE -> vote 1 at START, back to IDLE, no output pulse.
REQ-038 N=16, frame 0xA3 with stop bit 0 -> FrameErr_o pulse, no DataValid_o, and no new frame until the line returns to 1.
REQ-039 With PARITY_CHECK_EN, ParityOdd_i=0, byte 0x07 sent with parity bit 0 -> ParityErr_o pulse; with parity bit 1 -> DataValid_o pulse.
REQ-040 N=3 and N=1 (clamped to 3), back-to-back frames 0x00 then 0xFF -> both bytes received, two DataValid_o pulses.
REQ-041 rst asserted after data bit 4 of a frame -> all outputs 0 immediately; after release, no pulse for that frame, and the next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// UART receive sampler: 2-of-3 majority vote per bit, 8N1 framing.
// Define PARITY_CHECK_EN for 8-bit + parity + 1 stop framing.
module uart_rx_sampler (
  input  logic       clk,
  input  logic       rst,
  input  logic       AcqSig_i,
  input  logic [4:0] AcqPerBit_i,
  input  logic       Rx_i,
`ifdef PARITY_CHECK_EN
  input  logic       ParityOdd_i,
`endif
  output logic [7:0] Data_o,
  output logic       DataValid_o,
  output logic       FrameErr_o,
  output logic       ParityErr_o,
  output logic       Busy_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
`ifdef PARITY_CHECK_EN
    PARITY = 3'd3,
`endif
    STOP  = 3'd4
  } state_t;

  state_t     state, state_d;
  logic       rx_meta, rx_sync;
  logic       prev_smp, brk;
  logic [4:0] n_q, n_clamp;
  logic [3:0] cnt, idx;
  logic [2:0] bit_cnt;
  logic       v0, v1, voted;
  logic [7:0] shreg;
  logic       dv_q, fe_q;
  logic [4:0] idx5, m5;
  logic       at_lo, at_mid, at_hi, wrap;
  logic       start_edge, stop_vote;
`ifdef PARITY_CHECK_EN
  logic       perr_q, pe_q;
`else
  logic       perr_q;
  assign perr_q = 1'b0;
`endif

  always_comb begin
    n_clamp = AcqPerBit_i;
    if (AcqPerBit_i < 5'd3)
      n_clamp = 5'd3;
    else if (AcqPerBit_i > 5'd16)
      n_clamp = 5'd16;
  end

  // idx is the position of the current strobe within its bit
  assign idx = ({1'b0, cnt} == n_q - 5'd1) ? 4'd0 : cnt + 4'd1;
  assign idx5 = {1'b0, idx};
  assign m5 = {1'b0, n_q[4:1]};
  assign at_lo = idx5 == m5 - 5'd1;
  assign at_mid = idx5 == m5;
  assign at_hi = idx5 == m5 + 5'd1;
  assign wrap = idx == 4'd0;
  assign voted = (v0 & v1) | (v0 & rx_sync) | (v1 & rx_sync);
  assign start_edge = !rx_sync && prev_smp && !brk;
  assign stop_vote = AcqSig_i && state == STOP && at_hi;

  always_comb begin
    state_d = state;
    if (AcqSig_i) begin
      unique case (state)
        IDLE:
          if (start_edge) state_d = START;
        START:
          if (at_hi && voted) state_d = IDLE;
          else if (wrap) state_d = DATA;
        DATA:
          if (wrap && bit_cnt == 3'd7)
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
        PARITY:
          if (wrap) state_d = STOP;
`else
            state_d = STOP;
`endif
        STOP:
          if (at_hi) state_d = IDLE;
        default:
          state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      prev_smp <= 1'b1;
      brk <= 1'b0;
      n_q <= 5'd0;
      cnt <= 4'd0;
      bit_cnt <= 3'd0;
      v0 <= 1'b0;
      v1 <= 1'b0;
      shreg <= 8'h00;
      Data_o <= 8'h00;
      dv_q <= 1'b0;
      fe_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q <= 1'b0;
      pe_q <= 1'b0;
`endif
    end else begin
      rx_meta <= Rx_i;
      rx_sync <= rx_meta;
      state <= state_d;
      dv_q <= 1'b0;
      fe_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      pe_q <= 1'b0;
`endif
      if (AcqSig_i) begin
        prev_smp <= rx_sync;
        if (state == IDLE) begin
          if (rx_sync) brk <= 1'b0;
          if (start_edge) begin
            cnt <= 4'd0;
            n_q <= n_clamp;
            bit_cnt <= 3'd0;
            v0 <= rx_sync;
`ifdef PARITY_CHECK_EN
            perr_q <= 1'b0;
`endif
          end
        end else begin
          cnt <= idx;
          if (at_lo) v0 <= rx_sync;
          if (at_mid) v1 <= rx_sync;
          if (state == DATA && at_hi)
            shreg <= {voted, shreg[7:1]};
          if (state == DATA && wrap)
            bit_cnt <= bit_cnt + 3'd1;
`ifdef PARITY_CHECK_EN
          if (state == PARITY && at_hi)
            perr_q <= (^shreg ^ voted) != ParityOdd_i;
`endif
          if (stop_vote) begin
            Data_o <= shreg;
            dv_q <= voted & ~perr_q;
            fe_q <= ~voted;
            // a low stop bit is treated as a break until the line idles
            brk <= ~voted;
`ifdef PARITY_CHECK_EN
            pe_q <= perr_q;
`endif
          end
        end
      end
    end
  end

  assign DataValid_o = dv_q;
  assign FrameErr_o = fe_q;
  assign Busy_o = state != IDLE;
`ifdef PARITY_CHECK_EN
  assign ParityErr_o = pe_q;
`else
  assign ParityErr_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: frames, glitches,
// frame errors, clamped N, mid-frame reset, optional parity.
module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       AcqSig_i = 1'b0;
  logic [4:0] AcqPerBit_i = 5'd16;
  logic       Rx_i = 1'b1;
`ifdef PARITY_CHECK_EN
  logic       ParityOdd_i = 1'b0;
`endif
  logic [7:0] Data_o;
  logic       DataValid_o;
  logic       FrameErr_o;
  logic       ParityErr_o;
  logic       Busy_o;

  int n_chk = 0;
  int n_pass = 0;
  logic [10:0] sb[$];

  always #5 clk = ~clk;

  uart_rx_sampler dut (
    .clk(clk),
    .rst(rst),
    .AcqSig_i(AcqSig_i),
    .AcqPerBit_i(AcqPerBit_i),
    .Rx_i(Rx_i),
`ifdef PARITY_CHECK_EN
    .ParityOdd_i(ParityOdd_i),
`endif
    .Data_o(Data_o),
    .DataValid_o(DataValid_o),
    .FrameErr_o(FrameErr_o),
    .ParityErr_o(ParityErr_o),
    .Busy_o(Busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst && (DataValid_o || FrameErr_o || ParityErr_o)) begin
      if (sb.size() == 0)
        chk("sb_unexpected",
            {21'd0, ParityErr_o, FrameErr_o, DataValid_o, Data_o}, 32'd0);
      else
        chk("sb_frame",
            {21'd0, ParityErr_o, FrameErr_o, DataValid_o, Data_o},
            {21'd0, sb.pop_front()});
    end
  end

  task automatic strobe();
    repeat (3) @(negedge clk);
    AcqSig_i = 1'b1;
    @(negedge clk);
    AcqSig_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [4:0] nraw,
                            input bit stop, input bit par_bad,
                            input int abort, input bit twist);
    int n;
    int m;
    bit perr;
    n = (nraw < 5'd3) ? 3 : (nraw > 5'd16) ? 16 : int'(nraw);
    m = n / 2;
    AcqPerBit_i = nraw;
`ifdef PARITY_CHECK_EN
    perr = par_bad;
`else
    perr = 1'b0;
`endif
    if (abort < 0)
      sb.push_back({perr, !stop, stop && !perr, d});
    Rx_i = 1'b0;
    repeat (n) strobe();
    if (twist) AcqPerBit_i = 5'd7;
    for (int i = 0; i < 8; i++) begin
      Rx_i = d[i];
      repeat (n) strobe();
      if (twist && i == 2) begin
        repeat (40) @(negedge clk);
        chk("hold_busy", Busy_o, 1);
      end
      if (i == abort) return;
    end
`ifdef PARITY_CHECK_EN
    Rx_i = ^d ^ ParityOdd_i ^ par_bad;
    repeat (n) strobe();
`endif
    Rx_i = stop;
    repeat (m + 2) strobe();
    chk("lat_dv", DataValid_o, stop && !perr);
    chk("lat_fe", FrameErr_o, !stop);
    chk("data", Data_o, d);
    if (n - m - 2 > 0) repeat (n - m - 2) strobe();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", Data_o, 0);
    chk("rst_pulses", {DataValid_o, FrameErr_o, ParityErr_o}, 0);
    chk("rst_busy", Busy_o, 0);
    rst = 1'b1;
    repeat (3) strobe();

    send_frame(8'h55, 5'd16, 1, 0, -1, 0);
    repeat (2) strobe();
    chk("idle_busy", Busy_o, 0);

    Rx_i = 1'b0;
    repeat (3) strobe();
    chk("glitch_busy", Busy_o, 1);
    Rx_i = 1'b1;
    repeat (13) strobe();
    chk("glitch_idle", Busy_o, 0);
    repeat (3) strobe();

    send_frame(8'hA3, 5'd16, 0, 0, -1, 0);
    repeat (40) strobe();
    chk("break_idle", Busy_o, 0);
    Rx_i = 1'b1;
    repeat (4) strobe();
    send_frame(8'h3C, 5'd16, 1, 0, -1, 0);
    repeat (2) strobe();

`ifdef PARITY_CHECK_EN
    ParityOdd_i = 1'b0;
    send_frame(8'h07, 5'd16, 1, 1, -1, 0);
    repeat (2) strobe();
    send_frame(8'h07, 5'd16, 1, 0, -1, 0);
    repeat (2) strobe();
    ParityOdd_i = 1'b1;
    send_frame(8'h07, 5'd8, 1, 0, -1, 0);
    send_frame(8'hE1, 5'd8, 1, 1, -1, 0);
    repeat (2) strobe();
    ParityOdd_i = 1'b0;
`endif

    send_frame(8'h00, 5'd3, 1, 0, -1, 0);
    send_frame(8'hFF, 5'd3, 1, 0, -1, 0);
    send_frame(8'h00, 5'd1, 1, 0, -1, 0);
    send_frame(8'hFF, 5'd1, 1, 0, -1, 0);
    repeat (2) strobe();

    send_frame(8'h96, 5'd8, 1, 0, -1, 1);
    send_frame(8'h4B, 5'd31, 1, 0, -1, 0);
    repeat (2) strobe();

    send_frame(8'h5A, 5'd16, 1, 0, 4, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_data", Data_o, 0);
    chk("mid_rst_pulses", {DataValid_o, FrameErr_o, ParityErr_o}, 0);
    chk("mid_rst_busy", Busy_o, 0);
    Rx_i = 1'b1;
    repeat (5) strobe();
    rst = 1'b1;
    repeat (4) strobe();
    chk("post_rst_busy", Busy_o, 0);
    send_frame(8'hC3, 5'd16, 1, 0, -1, 0);

    repeat (10) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
